pulse_map_reader: RTL
=====================

Name: pulse_map_reader

Overview:
- Read-side counterpart of the pulse generator that fills the shared pulse-map BRAM with 1-entries at LFSR-chosen addresses.
- Sweeps the BRAM one slot at a time, at a fixed slot period. For every non-zero entry it emits a one-cycle pulse on pulse_out and counts it.
- Sits on port B of the pulse-map BRAM and drives the downstream detector/counter model as a time-ordered pulse train.

Parameters:
- DEPTH, 1024, number of 32-bit BRAM slots swept per frame (index 0..DEPTH-1).
- READ_LAT, 1, BRAM read latency in clocks from the ena/addr cycle to valid bram_data_out.
- SLOT_CYCLES, 8, clocks per slot. Effective value is max(SLOT_CYCLES, READ_LAT+3).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = sweep frames continuously.
- bram_addr  out  32  byte address, slot index * 4.
- bram_data_out  in  32  BRAM read data.
- bram_data_in  out  32  BRAM write data; always 0.
- ena  out  1  BRAM port enable.
- bram_we  out  1  BRAM write enable.
- pulse_out  out  1  one-cycle pulse per non-zero slot.
- frame_done  out  1  one-cycle pulse after slot DEPTH-1 completes.
- pulse_count  out  32  total pulses emitted, saturating.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (async, any time, including mid-slot):
  - state=IDLE, slot index=0, slot timer=0.
  - All outputs 0. An in-flight read or clear is abandoned.
- States: IDLE, ISSUE, WAIT, EVAL, CLEAR, PAD.
- IDLE:
  - run=1 -> ISSUE on the next clock.
  - Otherwise stay; ena=0, bram_we=0.
- ISSUE (cycle t, slot timer=0):
  - bram_addr=index*4, ena=1, bram_we=0 for exactly one cycle.
- WAIT:
  - ena=0; held for READ_LAT-1 further cycles.
  - If READ_LAT=1, go straight to EVAL.
- EVAL (cycle t+READ_LAT):
  - Register bram_data_out. Non-zero = any bit set.
  - If non-zero: pulse_out=1 during cycle t+READ_LAT+1 only.
  - If non-zero: pulse_count += 1, saturating at 0xFFFFFFFF.
- CLEAR (CLEAR_ON_READ_EN only, non-zero slot only, cycle t+READ_LAT+1):
  - ena=1, bram_we=1, bram_addr=index*4, bram_data_in=0.
- PAD:
  - ena=0 until the slot timer reaches effective SLOT_CYCLES-1.
  - The next ISSUE lands exactly at t+SLOT_CYCLES, so the slot period is constant whether the slot is empty or not.
- Slot end:
  - index < DEPTH-1 -> index+1.
  - index = DEPTH-1 -> frame_done=1 for one cycle (same cycle as the last slot's final PAD cycle), then index=0.
- Run control:
  - run sampled only at slot end. run=1 -> ISSUE; run=0 -> IDLE.
  - run dropped mid-slot: the slot finishes, including pulse and clear.
  - index and pulse_count are retained; re-asserting run resumes at the retained index.
- busy=1 in every state except IDLE.
- Address width: index held in ceil(log2(DEPTH)) bits, zero-extended, shifted left by 2.
- No write/read overlap: ena is never high two consecutive cycles except ISSUE followed by CLEAR when READ_LAT=0. READ_LAT=0 is not supported; minimum is 1.

Optional Feature:
- Macro: PULSE_MAP_READER_CLEAR_ON_READ_EN.
- Defined:
  - CLEAR state is active; each non-zero slot is written to 0 after its pulse.
  - The map is consumed once; the generator may refill it.
- Undefined:
  - CLEAR is never entered; bram_we stays 0 permanently.
  - The map is replayed unchanged every frame.

Test Plan:
- Reset mid-slot: assert rst while ena=1 -> all outputs 0 in the same cycle; after release with run=1 the first ISSUE uses bram_addr=0.
- DEPTH=16, SLOT_CYCLES=8, READ_LAT=1, slots 2, 5, 15 = 1, run=1:
  - pulse_out high at cycles 18, 42, 122 after the first ISSUE (=16+2, 40+2, 120+2).
  - frame_done at cycle 127.
  - pulse_count=3.
- Same map, CLEAR_ON_READ_EN defined, two frames:
  - Frame 1 gives 3 pulses plus 3 writes of 0 to addresses 0x08, 0x14, 0x3C.
  - Frame 2 gives 0 pulses; pulse_count stays 3.
- Same map, macro undefined, two frames -> pulse_count=6; bram_we never 1.
- run dropped at cycle 20 of frame 1 -> slot 2 completes, IDLE at cycle 24, busy=0. Run re-asserted -> next ISSUE at bram_addr=0x0C.
- pulse_count preloaded near saturation via 0xFFFFFFFE forced pulses, then 3 non-zero slots -> pulse_count=0xFFFFFFFF, no wrap.

Source files
------------

// File: rtl/pulse_map_reader.sv
// Sweeps the pulse-map BRAM one slot per fixed period, emitting a one-cycle pulse per non-zero entry.
// Define PULSE_MAP_READER_CLEAR_ON_READ_EN to write each non-zero slot back to 0 after its pulse.
module pulse_map_reader #(
    parameter int DEPTH       = 1024,
    parameter int READ_LAT    = 1,
    parameter int SLOT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [31:0] bram_addr,
    input  logic [31:0] bram_data_out,
    output logic [31:0] bram_data_in,
    output logic        ena,
    output logic        bram_we,
    output logic        pulse_out,
    output logic        frame_done,
    output logic [31:0] pulse_count,
    output logic        busy
);

    localparam int EFF_SLOT = (SLOT_CYCLES > READ_LAT + 3) ? SLOT_CYCLES : READ_LAT + 3;
    localparam int IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW       = $clog2(EFF_SLOT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, CLEAR, PAD} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pulse_q, pulse_d;
    logic [31:0]   pulse_count_q, pulse_count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            pulse_q       <= 1'b0;
            pulse_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            pulse_q       <= pulse_d;
            pulse_count_q <= pulse_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q + 1'b1;
        pulse_d       = 1'b0;
        pulse_count_d = pulse_count_q;
        ena           = 1'b0;
        bram_we       = 1'b0;
        frame_done    = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (run) state_d = ISSUE;
            end
            ISSUE: begin
                ena     = 1'b1;
                state_d = (READ_LAT <= 1) ? EVAL : WAIT;
            end
            WAIT: begin
                if (timer_q == TW'(READ_LAT - 1)) state_d = EVAL;
            end
            EVAL: begin
                state_d = PAD;
                if (|bram_data_out) begin
                    pulse_d = 1'b1;
                    if (pulse_count_q != 32'hFFFF_FFFF) pulse_count_d = pulse_count_q + 32'd1;
`ifdef PULSE_MAP_READER_CLEAR_ON_READ_EN
                    state_d = CLEAR;
`endif
                end
            end
            CLEAR: begin
`ifdef PULSE_MAP_READER_CLEAR_ON_READ_EN
                ena     = 1'b1;
                bram_we = 1'b1;
`endif
                state_d = PAD;
            end
            PAD: begin
                // Slot end is timer-based so empty and full slots take the same time.
                if (timer_q == TW'(EFF_SLOT - 1)) begin
                    timer_d = '0;
                    state_d = run ? ISSUE : IDLE;
                    if (idx_q == IW'(DEPTH - 1)) begin
                        frame_done = 1'b1;
                        idx_d      = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bram_addr    = {{(30 - IW){1'b0}}, idx_q, 2'b00};
    assign bram_data_in = 32'd0;
    assign pulse_out    = pulse_q;
    assign pulse_count  = pulse_count_q;
    assign busy         = (state_q != IDLE);

endmodule
